ssd_scan_driver: RTL and testbench

//  Time-multiplexed 4-digit seven-segment scan driver; sits directly downstream of the calculator core.

---
 rtl/calc_disp_pkg.sv | 27 ++
 rtl/ssd_slot_timer.sv | 52 +++++
 rtl/ssd_scan_driver.sv | 93 +++++++++
 tb/tb_ssd_scan_driver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared seven-segment glyph constants and scan FSM state type.
// The calculator core uses the same glyphs, so keep them in step with it.
package calc_disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hFD;
    localparam logic [7:0] SEG_E     = 8'h61;
    localparam logic [7:0] SEG_R     = 8'hF5;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // "Err" spelled across digits 3..1, digit 0 left dark.
    function automatic logic [7:0] err_glyph(input logic [1:0] idx);
        logic [7:0] g;
        case (idx)
            2'd3:    g = SEG_E;
            2'd2:    g = SEG_R;
            2'd1:    g = SEG_R;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Per-digit slot timer: a prescaler that splits each slot into a blank phase
// followed by a drive phase. Control outputs describe the *next* cycle.
module ssd_slot_timer
    import calc_disp_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 500
) (
    input  logic clk,
    input  logic rst,
    output logic drive_next,
    output logic slot_load,
    output logic end_of_slot
);

    localparam int PW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_DIGIT - 1);

    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;
    scan_state_t   state_reg;
    scan_state_t   state_next;
    logic          in_blank;

    generate
        if (BLANK_TICKS > 0) begin : g_blank
            assign in_blank = (presc_next < PW'(BLANK_TICKS));
        end else begin : g_no_blank
            assign in_blank = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg <= '0;
            state_reg <= BLANK;
        end else begin
            presc_reg <= presc_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        presc_next  = (presc_reg == LAST) ? '0 : presc_reg + 1'b1;
        state_next  = in_blank ? BLANK : DRIVE;
        end_of_slot = (presc_next == '0);
        drive_next  = (state_next == DRIVE);
        // With no blanking, DRIVE follows DRIVE, so a new slot must reload too.
        slot_load   = drive_next && ((state_reg == BLANK) || end_of_slot);
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with inter-digit blanking.
// The segment pattern for a slot is captured once when it starts driving.
module ssd_scan_driver
    import calc_disp_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        error,
    input  logic        neg,
    input  logic [1:0]  sign_pos,
    input  logic [31:0] bank_a,
    input  logic [31:0] bank_b,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [1:0]  digit_idx,
    output logic        frame_strobe
);

    logic drive_next;
    logic slot_load;
    logic end_of_slot;

    ssd_slot_timer #(
        .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
        .BLANK_TICKS     (BLANK_TICKS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .drive_next  (drive_next),
        .slot_load   (slot_load),
        .end_of_slot (end_of_slot)
    );

    logic [3:0][7:0] glyph;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign glyph[gi] = mode                            ? bank_a[8*gi +: 8] :
                               error                           ? err_glyph(2'(gi)) :
                               (neg && (sign_pos == 2'(gi)))   ? SEG_MINUS :
                                                                 bank_b[8*gi +: 8];
        end
    endgenerate

    logic [1:0] digit_reg, digit_next;
    logic [3:0] an_reg, an_next;
    logic [7:0] seg_reg, seg_next;
    logic       strobe_reg, strobe_next;

    always_comb begin
        digit_next  = digit_reg;
        strobe_next = 1'b0;
        an_next     = 4'hF;
        seg_next    = SEG_BLANK;
        if (end_of_slot) begin
            digit_next  = digit_reg + 2'd1;
            strobe_next = (digit_reg == 2'd3);
        end
        if (drive_next) begin
            if (slot_load) begin
                an_next  = ~(4'b0001 << digit_next);
                seg_next = glyph[digit_next];
            end else begin
                an_next  = an_reg;
                seg_next = seg_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_reg  <= 2'd0;
            an_reg     <= 4'hF;
            seg_reg    <= SEG_BLANK;
            strobe_reg <= 1'b0;
        end else begin
            digit_reg  <= digit_next;
            an_reg     <= an_next;
            seg_reg    <= seg_next;
            strobe_reg <= strobe_next;
        end
    end

    assign an           = an_reg;
    assign seg          = seg_reg;
    assign digit_idx    = digit_reg;
    assign frame_strobe = strobe_reg;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver with 8-cycle slots and 2 blank cycles.
module tb_ssd_scan_driver;

    localparam int TPD = 8;
    localparam int BT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0, error = 1'b0, neg = 1'b0;
    logic [1:0]  sign_pos = 2'd0;
    logic [31:0] bank_a = '0, bank_b = '0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_strobe;

    always #5 clk = ~clk;

    ssd_scan_driver #(.TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BT)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .error        (error),
        .neg          (neg),
        .sign_pos     (sign_pos),
        .bank_a       (bank_a),
        .bank_b       (bank_b),
        .an           (an),
        .seg          (seg),
        .digit_idx    (digit_idx),
        .frame_strobe (frame_strobe)
    );

    int         total = 0;
    int         bad   = 0;
    int         t     = 0;
    logic [7:0] snap  = 8'hFF;

    typedef struct {
        logic        mode, error, neg;
        logic [1:0]  sp;
        logic [31:0] ba, bb;
        logic [31:0] exp;   // expected glyphs, digit 3 in the top byte
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    // Reference glyph for digit idx from the current inputs.
    function automatic logic [7:0] ref_pat(input int idx);
        logic [31:0] err_word;
        err_word = 32'h61F5F5FF;
        if (mode)                    return bank_a[8*idx +: 8];
        if (error)                   return err_word[8*idx +: 8];
        if (neg && int'(sign_pos) == idx) return 8'hFD;
        return bank_b[8*idx +: 8];
    endfunction

    // Check all outputs for the current cycle t; drive_seg is the glyph due while driving.
    task automatic expect_cycle(input string tag, input logic [7:0] drive_seg);
        int         d;
        bit         drv;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic [1:0] exp_d;
        logic       exp_fs;
        d       = (t / TPD) % 4;
        drv     = (t % TPD) >= BT;
        exp_an  = drv ? ~(4'b0001 << d) : 4'hF;
        exp_seg = drv ? drive_seg : 8'hFF;
        exp_d   = 2'(d);
        exp_fs  = (t != 0) && (t % (4 * TPD) == 0);
        chk({tag, "_an"},  {28'd0, an},           {28'd0, exp_an});
        chk({tag, "_seg"}, {24'd0, seg},          {24'd0, exp_seg});
        chk({tag, "_dig"}, {30'd0, digit_idx},    {30'd0, exp_d});
        chk({tag, "_fs"},  {31'd0, frame_strobe}, {31'd0, exp_fs});
    endtask

    // Advance one cycle; inputs present now are what the next slot start captures.
    task automatic tick();
        if (((t + 1) % TPD) == BT) snap = ref_pat(((t + 1) / TPD) % 4);
        @(negedge clk);
        t++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_an",  {28'd0, an},           32'hF);
        chk("rst_seg", {24'd0, seg},          32'hFF);
        chk("rst_dig", {30'd0, digit_idx},    32'd0);
        chk("rst_fs",  {31'd0, frame_strobe}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        t   = 0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'hC0F9A4B0, 32'h00000000, 32'hC0F9A4B0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h11111111, 32'hC0C0F9A4, 32'hC0FDF9A4};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h11111111, 32'hC0C0F9A4, 32'h61F5F5FF};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 2'd3, 32'hC0F9A4B0, 32'h12345678, 32'hC0F9A4B0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'hC0F9A4B0, 32'h12345678, 32'h123456FD};

        // Table: one full frame plus the start of the next per vector.
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode; error = vecs[i].error; neg = vecs[i].neg;
            sign_pos = vecs[i].sp; bank_a = vecs[i].ba; bank_b = vecs[i].bb;
            do_reset();
            for (int c = 0; c < 4 * TPD + 3; c++) begin
                expect_cycle($sformatf("vec%0d", i), vecs[i].exp[8*((t / TPD) % 4) +: 8]);
                tick();
            end
            $display("vector %0d applied through cycle %0d", i, t);
        end

        // Mid-drive input change is held off until the next digit-0 slot.
        mode = 1'b1; error = 1'b0; neg = 1'b0; bank_a = 32'hC0F9A4B0;
        do_reset();
        while (t < 5) begin expect_cycle("snap_pre", snap); tick(); end
        bank_a[7:0] = 8'h99;
        chk("snap_hold5", {24'd0, seg}, 32'hB0);
        tick();
        chk("snap_hold6", {24'd0, seg}, 32'hB0);
        tick();
        chk("snap_hold7", {24'd0, seg}, 32'hB0);
        while (t < 34) begin tick(); end
        chk("snap_new_seg", {24'd0, seg}, 32'h99);
        chk("snap_new_an",  {28'd0, an},  32'hE);
        $display("snapshot sequence done at cycle %0d", t);

        // Asynchronous reset in the middle of digit 1's drive.
        bank_a = 32'hC0F9A4B0;
        do_reset();
        while (t < 12) begin tick(); end
        chk("mid_an_before", {28'd0, an}, 32'hD);
        rst = 1'b0;
        #1;
        chk("mid_rst_an",  {28'd0, an},        32'hF);
        chk("mid_rst_seg", {24'd0, seg},       32'hFF);
        chk("mid_rst_dig", {30'd0, digit_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        t   = 0;
        for (int c = 0; c < 3; c++) begin expect_cycle("mid_rel", snap); tick(); end
        chk("mid_rel_an2",  {28'd0, an},  32'hE);
        chk("mid_rel_seg2", {24'd0, seg}, 32'hB0);
        $display("mid-drive reset sequence done");

        // Random run against the model; inputs change at arbitrary cycles.
        mode = 1'b0;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            expect_cycle("rnd", snap);
            if ($urandom_range(2) == 0) begin
                mode     = 1'($urandom_range(1));
                error    = 1'($urandom_range(3) == 0);
                neg      = 1'($urandom_range(1));
                sign_pos = 2'($urandom_range(3));
                bank_a   = $urandom;
                bank_b   = $urandom;
            end
            tick();
        end
        $display("random run done, %0d cycles", t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
